// File: rtl/mips_halt_dump_unit.sv
// End-of-program detector for single_cycle_mips: traces PC changes, freezes the CPU at END_PC
// and streams a window of data-memory words over a valid/ready port.
module mips_halt_dump_unit #(
    parameter logic [31:0] END_PC     = 32'h9C,
    parameter int          DUMP_BASE  = 50,
    parameter int          DUMP_COUNT = 21
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    output logic        halt,
    output logic        pc_change,
    output logic [31:0] pc_trace,
    output logic [31:0] dmem_addr,
    input  logic [31:0] dmem_rdata,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic [31:0] dump_data,
    output logic [7:0]  dump_index,
    output logic        done
);

    // state  | meaning
    // S_RUN  | CPU executing, PC traced
    // S_DUMP | CPU frozen, memory window streaming out
    // S_DONE | all words accepted, frozen until reset
    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_DUMP = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [7:0]  COUNT8 = 8'(DUMP_COUNT);
    localparam logic [31:0] BASE32 = 32'(DUMP_BASE);

    logic [1:0]  state;
    logic [7:0]  idx;
    logic [31:0] prev_pc;
    logic        at_end;
    logic        load;
    logic        finish;

    assign at_end = (pc_in == END_PC);

    // Combinational so the END_PC instruction is frozen in the very cycle it appears.
    assign halt = (state != S_RUN) || (at_end && !reset);

    assign dmem_addr = (state == S_DUMP) ? ((BASE32 + {24'd0, idx}) << 2) : 32'd0;

    assign load   = (state == S_DUMP) && (idx < COUNT8) && (!dump_valid || dump_ready);
    assign finish = (state == S_DUMP) && (idx == COUNT8) && dump_valid && dump_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_RUN;
            idx        <= 8'd0;
            prev_pc    <= pc_in;
            pc_change  <= 1'b0;
            pc_trace   <= 32'd0;
            dump_valid <= 1'b0;
            dump_data  <= 32'd0;
            dump_index <= 8'd0;
            done       <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    prev_pc  <= pc_in;
                    pc_trace <= pc_in;
                    if (at_end) begin
                        // END_PC never commits, so it is not reported as a PC change.
                        state     <= S_DUMP;
                        idx       <= 8'd0;
                        pc_change <= 1'b0;
                    end else begin
                        pc_change <= (pc_in != prev_pc);
                    end
                end
                S_DUMP: begin
                    pc_change <= 1'b0;
                    if (load) begin
                        dump_data  <= dmem_rdata;
                        dump_index <= idx;
                        dump_valid <= 1'b1;
                        idx        <= idx + 8'd1;
                    end else if (finish) begin
                        dump_valid <= 1'b0;
                        done       <= 1'b1;
                        state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    pc_change <= 1'b0;
                end
                default: begin
                    state     <= S_RUN;
                    pc_change <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_halt_dump_unit.sv
// Directed self-checking bench for mips_halt_dump_unit with a combinational data-memory model.
module tb_mips_halt_dump_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in;
    logic        halt;
    logic        pc_change;
    logic [31:0] pc_trace;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_rdata;
    logic        dump_valid;
    logic        dump_ready;
    logic [31:0] dump_data;
    logic [7:0]  dump_index;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_idx  = 0;

    always #5 clk = ~clk;

    mips_halt_dump_unit dut (
        .clk        (clk),
        .reset      (reset),
        .pc_in      (pc_in),
        .halt       (halt),
        .pc_change  (pc_change),
        .pc_trace   (pc_trace),
        .dmem_addr  (dmem_addr),
        .dmem_rdata (dmem_rdata),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_data  (dump_data),
        .dump_index (dump_index),
        .done       (done)
    );

    assign dmem_rdata = {dmem_addr[15:0], ~dmem_addr[15:0]};

    function automatic logic [31:0] exp_word(input int i);
        logic [31:0] a;
        a = 32'((50 + i) * 4);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled at the falling edge.
    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #4;
    endtask

    task automatic dump_cycle(input logic rdy);
        next_cycle();
        dump_ready = rdy;
        settle();
        if (dump_valid) begin
            check_val("dump_index", 32'(dump_index), 32'(exp_idx));
            check_val("dump_data", dump_data, exp_word(exp_idx));
            if (rdy) exp_idx++;
        end
    endtask

    initial begin
        reset      = 1'b1;
        pc_in      = 32'hFFFF_FFFC;
        dump_ready = 1'b0;

        // Test 1: reset and PC tracing
        repeat (3) next_cycle();
        settle();
        check_val("rst_halt", 32'(halt), 0);
        check_val("rst_valid", 32'(dump_valid), 0);
        next_cycle();
        reset = 1'b0;
        pc_in = 32'h0;
        settle();
        check_val("post_rst_pc_change", 32'(pc_change), 0);
        check_val("post_rst_trace", pc_trace, 0);
        check_val("post_rst_addr", dmem_addr, 0);
        check_val("post_rst_done", 32'(done), 0);
        check_val("run_halt", 32'(halt), 0);
        next_cycle(); pc_in = 32'h4; settle();
        check_val("pc_change_0", 32'(pc_change), 1);
        check_val("pc_trace_0", pc_trace, 32'h0);
        next_cycle(); pc_in = 32'h8; settle();
        check_val("pc_change_4", 32'(pc_change), 1);
        check_val("pc_trace_4", pc_trace, 32'h4);
        next_cycle(); settle();
        check_val("pc_change_8", 32'(pc_change), 1);
        check_val("pc_trace_8", pc_trace, 32'h8);
        next_cycle(); settle();
        check_val("pc_hold_no_change", 32'(pc_change), 0);

        // Test 2: END_PC detection and full back-to-back dump
        next_cycle();
        pc_in      = 32'h9C;
        dump_ready = 1'b1;
        settle();
        check_val("halt_same_cycle", 32'(halt), 1);
        next_cycle(); settle();
        check_val("first_addr", dmem_addr, 32'hC8);
        check_val("first_not_valid", 32'(dump_valid), 0);
        check_val("dump_pc_change", 32'(pc_change), 0);
        for (int i = 0; i < 21; i++) begin
            next_cycle(); settle();
            check_val("b2b_valid", 32'(dump_valid), 1);
            check_val("b2b_index", 32'(dump_index), 32'(i));
            check_val("b2b_data", dump_data, exp_word(i));
            check_val("b2b_done", 32'(done), 0);
        end
        next_cycle(); settle();
        check_val("done_set", 32'(done), 1);
        check_val("done_valid", 32'(dump_valid), 0);
        check_val("done_addr", dmem_addr, 0);

        // Test 6: DONE ignores pc_in and dump_ready
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            pc_in      = 32'(i * 4);
            dump_ready = i[0];
            settle();
            check_val("done_sticky", 32'(done), 1);
            check_val("done_halt", 32'(halt), 1);
            check_val("done_no_change", 32'(pc_change), 0);
            check_val("done_no_valid", 32'(dump_valid), 0);
        end

        // Test 5: END_PC while in reset does not halt
        next_cycle();
        reset      = 1'b1;
        pc_in      = 32'h9C;
        dump_ready = 1'b1;
        next_cycle(); settle();
        check_val("rst_endpc_halt", 32'(halt), 0);
        check_val("rst_endpc_done", 32'(done), 0);
        next_cycle();
        reset = 1'b0;
        settle();
        check_val("rel_endpc_halt", 32'(halt), 1);

        // Test 3: stall on word 5
        exp_idx = 0;
        dump_cycle(1'b1);
        repeat (5) dump_cycle(1'b1);
        check_val("pre_stall_count", 32'(exp_idx), 5);
        repeat (3) begin
            dump_cycle(1'b0);
            check_val("stall_valid", 32'(dump_valid), 1);
            check_val("stall_addr", dmem_addr, 32'hE0);
        end
        repeat (5) dump_cycle(1'b1);
        check_val("post_stall_count", 32'(exp_idx), 10);

        // Test 4: reset during word 10, then restart from index 0
        next_cycle();
        reset = 1'b1;
        pc_in = 32'h0;
        settle();
        check_val("word10_index", 32'(dump_index), 10);
        next_cycle();
        reset = 1'b0;
        settle();
        check_val("abort_halt", 32'(halt), 0);
        check_val("abort_valid", 32'(dump_valid), 0);
        check_val("abort_addr", dmem_addr, 0);
        check_val("abort_done", 32'(done), 0);
        next_cycle();
        pc_in = 32'h9C;
        exp_idx = 0;
        for (int i = 0; i < 30 && !done; i++) dump_cycle(1'b1);
        check_val("restart_words", 32'(exp_idx), 21);
        check_val("restart_done", 32'(done), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
